amstrad_mem_arbiter: RTL and testbench
======================================

# amstrad_mem_arbiter

Single-port memory arbiter that shares the 16-bit system RAM between three requesters: the video fetch path, the Z80 bus and the ROM/snapshot loader. It sits between the motherboard's address and data buses and the external RAM controller. It serialises their accesses with fixed priority (video > CPU > loader). It returns read data and a one-cycle completion strobe to each requester.

## Interface
Parameters:
- `VID_BASE`, default 0, word address (22 bits) added to every video fetch address.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `vid_req`  in  1  one-cycle pulse: fetch one word for video
- `vid_addr`  in  15  video word address
- `vid_data`  out  16  fetched video word, registered
- `vid_valid`  out  1  one-cycle pulse; `vid_data` valid
- `vid_overrun`  out  1  sticky; new `vid_req` arrived while one was still pending
- `cpu_rd`, `cpu_wr`  in  1  level CPU memory strobes (mutually exclusive)
- `cpu_addr`  in  23  CPU byte address (post-MMU)
- `cpu_wdata`  in  8  CPU write byte
- `cpu_rdata`  out  8  CPU read byte, registered
- `cpu_done`  out  1  one-cycle pulse; access complete
- `ld_wr`  in  1  one-cycle pulse: loader write request
- `ld_addr`  in  23  loader byte address
- `ld_wdata`  in  8  loader byte
- `ld_done`  out  1  one-cycle pulse; loader write committed
- `mem_req`  out  1  request to RAM controller, held until ack
- `mem_we`  out  1  write when 1
- `mem_addr`  out  22  word address
- `mem_be`  out  2  byte enables, writes only ([1]=high byte)
- `mem_wdata`  out  16  write data (byte replicated on both lanes)
- `mem_rdata`  in  16  read data, valid in the `mem_ack` cycle
- `mem_ack`  in  1  one-cycle completion from RAM controller
- `loader_active`  in  1  loader session in progress (used only under `LOADER_HOLD_EN`)

## Operation
- Pending flags: `vpend` is set by a `vid_req` pulse. `cpend` is set by a rising edge of `cpu_rd|cpu_wr`; the direction and address are latched at that edge. `lpend` is set by an `ld_wr` pulse; address and data are latched at that pulse.
- A `vid_req` while `vpend=1` sets `vid_overrun`. The request is merged and the newer `vid_addr` is used. `vid_overrun` clears only on reset.
- `ld_wr` while `lpend=1` is a protocol error. The later address/data overwrites the earlier one.
- FSM states: IDLE, VID, CPU, LD.
  - IDLE transitions to VID if `vpend`, else to CPU if `cpend`, else to LD if `lpend`.
  - VID, CPU and LD each return to IDLE on `mem_ack`.
  - The pending flag of the granted requester clears on grant entry.
- In each busy state, `mem_req=1`, with `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` stable until `mem_ack`.
- Video access: `mem_addr = VID_BASE + vid_addr` (zero-extended, modulo 2^22), `mem_we=0`.
- CPU/loader access: `mem_addr = addr[22:1]`.
  - Write: `mem_be = addr[0] ? 2'b10 : 2'b01`.
  - Read: `mem_be=2'b00`; `cpu_rdata = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]`.
- The arbiter is non-preemptive; an in-flight access always completes.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all pending flags and latched addresses 0.
- Request to `mem_req` latency: flag set in cycle N; IDLE decides in N+1; `mem_req` rises in N+2 when the memory port is idle.
- `mem_ack` in cycle M:
  - FSM is IDLE in M+1.
  - `vid_valid`/`cpu_done`/`ld_done` pulse in M+1, with data registered in M+1.
  - The next grant can be issued in M+2.
- A request arriving in the same cycle as `mem_ack` is not lost; it is arbitrated from IDLE.
- The CPU must hold `cpu_rd`/`cpu_wr` until `cpu_done`. A strobe dropped early still completes the latched access, and `cpu_done` still pulses.
- Reset asserted mid-access drops `mem_req` immediately (asynchronous). The RAM controller must tolerate an abandoned request.

## Configuration
- `LOADER_HOLD_EN` defined:
  - While `loader_active=1`, a CPU edge still sets `cpend`, but `cpend` is not granted; `cpu_done` is withheld, stalling the Z80 via wait.
  - Loader priority rises above CPU (video still highest).
  - When `loader_active` falls, the held CPU access is served normally.
- Not defined: `loader_active` is ignored and fixed priority video > CPU > loader applies always.

## Test plan
- Single video fetch with `mem_ack` 3 cycles after `mem_req`, `vid_addr=15'h1234`, `VID_BASE=0`, `mem_rdata=16'hBEEF` -> `mem_addr=22'h001234`, `vid_valid` one cycle, `vid_data=16'hBEEF`.
- CPU read at `23'h00C001` with `mem_rdata=16'hA55A` -> `mem_addr=22'h006000`, `cpu_rdata=8'hA5`, one `cpu_done` pulse. CPU write at even address `8'h3C` -> `mem_be=2'b01`, `mem_wdata=16'h3C3C`.
- `vid_req`, `cpu_rd` edge and `ld_wr` in the same cycle -> grants in order VID, CPU, LD, with exactly one completion pulse each.
- Two `vid_req` pulses without an intervening grant -> one memory access at the second address; `vid_overrun=1` sticky until reset.
- `reset` asserted while `mem_req=1` -> `mem_req=0` in the same cycle; all pending flags cleared; no done pulses after release.
- `LOADER_HOLD_EN` defined, `loader_active=1`, CPU read plus loader write -> LD served, `cpu_done` held low; after `loader_active` falls, CPU is served within 3 cycles of the port going idle.

Source files
------------

// File: rtl/amstrad_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : amstrad_mem_arbiter
// Purpose  : Shares one 16-bit RAM port between video fetch, Z80 bus and the
//            ROM/snapshot loader with fixed priority video > CPU > loader.
//            Build macro LOADER_HOLD_EN: while i_loader_active is high, CPU
//            grants are withheld and the loader ranks above the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module amstrad_mem_arbiter #(
  parameter logic [21:0] VID_BASE = 22'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_vid_req,
  input  logic [14:0] i_vid_addr,
  output logic [15:0] o_vid_data,
  output logic        o_vid_valid,
  output logic        o_vid_overrun,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [22:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_done,
  input  logic        i_ld_wr,
  input  logic [22:0] i_ld_addr,
  input  logic [7:0]  i_ld_wdata,
  output logic        o_ld_done,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [21:0] o_mem_addr,
  output logic [1:0]  o_mem_be,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  input  logic        i_loader_active
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;
  localparam logic [1:0] S_LD   = 2'd3;

  logic [1:0]  r_state;

  logic        r_vpend;
  logic [14:0] r_vaddr;
  logic        r_overrun;

  logic        r_cpu_strb_q;
  logic        r_cpend;
  logic        r_cwe;
  logic [22:0] r_caddr;
  logic [7:0]  r_cwdata;

  logic        r_lpend;
  logic [22:0] r_laddr;
  logic [7:0]  r_lwdata;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [21:0] r_mem_addr;
  logic [1:0]  r_mem_be;
  logic [15:0] r_mem_wdata;
  logic        r_sel_hi;

  logic [15:0] r_vid_data;
  logic        r_vid_valid;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_done;
  logic        r_ld_done;

  logic        w_cpu_strb;
  logic        w_cpu_edge;
  logic [1:0]  w_grant;
  logic        w_nxt_we;
  logic [21:0] w_nxt_addr;
  logic [1:0]  w_nxt_be;
  logic [15:0] w_nxt_wdata;
  logic        w_nxt_hi;

  assign w_cpu_strb = i_cpu_rd | i_cpu_wr;
  assign w_cpu_edge = w_cpu_strb & ~r_cpu_strb_q;

  // Grant decision is only ever non-idle while the port is free.
  always_comb begin
    w_grant = S_IDLE;
    if (r_state == S_IDLE) begin
`ifdef LOADER_HOLD_EN
      if (r_vpend) begin
        w_grant = S_VID;
      end else if (i_loader_active) begin
        if (r_lpend) begin
          w_grant = S_LD;
        end
      end else if (r_cpend) begin
        w_grant = S_CPU;
      end else if (r_lpend) begin
        w_grant = S_LD;
      end
`else
      if (r_vpend) begin
        w_grant = S_VID;
      end else if (r_cpend) begin
        w_grant = S_CPU;
      end else if (r_lpend) begin
        w_grant = S_LD;
      end
`endif
    end
  end

`ifndef LOADER_HOLD_EN
  logic w_unused_loader_active;
  assign w_unused_loader_active = i_loader_active;
`endif

  always_comb begin
    w_nxt_we    = 1'b0;
    w_nxt_addr  = 22'd0;
    w_nxt_be    = 2'b00;
    w_nxt_wdata = 16'd0;
    w_nxt_hi    = 1'b0;
    case (w_grant)
      S_VID: begin
        w_nxt_addr = VID_BASE + {7'd0, r_vaddr};
      end
      S_CPU: begin
        w_nxt_we   = r_cwe;
        w_nxt_addr = r_caddr[22:1];
        w_nxt_hi   = r_caddr[0];
        if (r_cwe) begin
          w_nxt_be    = r_caddr[0] ? 2'b10 : 2'b01;
          w_nxt_wdata = {r_cwdata, r_cwdata};
        end
      end
      S_LD: begin
        w_nxt_we    = 1'b1;
        w_nxt_addr  = r_laddr[22:1];
        w_nxt_hi    = r_laddr[0];
        w_nxt_be    = r_laddr[0] ? 2'b10 : 2'b01;
        w_nxt_wdata = {r_lwdata, r_lwdata};
      end
      default: begin
      end
    endcase
  end

  // A new request in the grant cycle wins over the clear so it is not lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vpend   <= 1'b0;
      r_vaddr   <= 15'd0;
      r_overrun <= 1'b0;
    end else begin
      if (i_vid_req) begin
        r_vpend <= 1'b1;
        r_vaddr <= i_vid_addr;
        if (r_vpend) begin
          r_overrun <= 1'b1;
        end
      end else if (w_grant == S_VID) begin
        r_vpend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cpu_strb_q <= 1'b0;
      r_cpend      <= 1'b0;
      r_cwe        <= 1'b0;
      r_caddr      <= 23'd0;
      r_cwdata     <= 8'd0;
    end else begin
      r_cpu_strb_q <= w_cpu_strb;
      if (w_cpu_edge) begin
        r_cpend  <= 1'b1;
        r_cwe    <= i_cpu_wr;
        r_caddr  <= i_cpu_addr;
        r_cwdata <= i_cpu_wdata;
      end else if (w_grant == S_CPU) begin
        r_cpend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lpend  <= 1'b0;
      r_laddr  <= 23'd0;
      r_lwdata <= 8'd0;
    end else begin
      if (i_ld_wr) begin
        r_lpend  <= 1'b1;
        r_laddr  <= i_ld_addr;
        r_lwdata <= i_ld_wdata;
      end else if (w_grant == S_LD) begin
        r_lpend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 22'd0;
      r_mem_be    <= 2'b00;
      r_mem_wdata <= 16'd0;
      r_sel_hi    <= 1'b0;
      r_vid_data  <= 16'd0;
      r_vid_valid <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_cpu_done  <= 1'b0;
      r_ld_done   <= 1'b0;
    end else begin
      r_vid_valid <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_ld_done   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_grant != S_IDLE) begin
          r_state     <= w_grant;
          r_mem_req   <= 1'b1;
          r_mem_we    <= w_nxt_we;
          r_mem_addr  <= w_nxt_addr;
          r_mem_be    <= w_nxt_be;
          r_mem_wdata <= w_nxt_wdata;
          r_sel_hi    <= w_nxt_hi;
        end
      end else if (i_mem_ack) begin
        r_state   <= S_IDLE;
        r_mem_req <= 1'b0;
        case (r_state)
          S_VID: begin
            r_vid_data  <= i_mem_rdata;
            r_vid_valid <= 1'b1;
          end
          S_CPU: begin
            r_cpu_done <= 1'b1;
            if (!r_mem_we) begin
              r_cpu_rdata <= r_sel_hi ? i_mem_rdata[15:8] : i_mem_rdata[7:0];
            end
          end
          S_LD: begin
            r_ld_done <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_vid_data    = r_vid_data;
  assign o_vid_valid   = r_vid_valid;
  assign o_vid_overrun = r_overrun;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_cpu_done    = r_cpu_done;
  assign o_ld_done     = r_ld_done;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_be      = r_mem_be;
  assign o_mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_amstrad_mem_arbiter.sv
`default_nettype none
// Scoreboard bench for amstrad_mem_arbiter: RAM responder plus completion
// monitor pop expectations queued by randomized rounds and directed cases.
`timescale 1ns/1ps
module tb_amstrad_mem_arbiter;

  localparam logic [21:0] VB = 22'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        vid_overrun;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        ld_wr;
  logic [22:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_done;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        loader_active;

  amstrad_mem_arbiter #(.VID_BASE(VB)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_data(vid_data),
    .o_vid_valid(vid_valid), .o_vid_overrun(vid_overrun),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_done(cpu_done),
    .i_ld_wr(ld_wr), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .o_ld_done(ld_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .i_loader_active(loader_active)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [21:0] addr; logic [1:0] be; logic [15:0] wdata; } txn_t;
  typedef struct packed { logic rd; logic [7:0] data; } cexp_t;

  txn_t        exp_txn[$];
  logic [15:0] exp_vid[$];
  cexp_t       exp_cpu[$];
  int          exp_ld[$];
  logic [15:0] ram [int];
  logic [15:0] mdl [int];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cyc = 0, ack_cyc = 0, vld_cyc = 0;
  int ack_delay = -1;
  logic ram_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  function automatic logic [15:0] init_word(input logic [21:0] a);
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  function automatic logic [15:0] mread(input logic [21:0] a);
    if (mdl.exists(int'(a))) return mdl[int'(a)];
    return init_word(a);
  endfunction

  task automatic mwrite(input logic [21:0] a, input logic hi, input logic [7:0] d);
    logic [15:0] w;
    w = mread(a);
    if (hi) w[15:8] = d; else w[7:0] = d;
    mdl[int'(a)] = w;
  endtask

  task automatic preload(input logic [21:0] a, input logic [15:0] d);
    mdl[int'(a)] = d;
    ram[int'(a)] = d;
  endtask

  task automatic push_txn(input logic we, input logic [21:0] a, input logic [1:0] be, input logic [15:0] wd);
    txn_t t;
    t.we = we; t.addr = a; t.be = be; t.wdata = wd;
    exp_txn.push_back(t);
  endtask

  task automatic push_cpu(input logic rd, input logic [7:0] d);
    cexp_t c;
    c.rd = rd; c.data = d;
    exp_cpu.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM controller model: checks each new request, then acks after a delay.
  initial begin : ram_proc
    txn_t t, e;
    logic [15:0] w;
    int d, k;
    logic stable;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        t.we = mem_we; t.addr = mem_addr; t.be = mem_be; t.wdata = mem_wdata;
        req_cyc = cyc;
        if (exp_txn.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          e = exp_txn.pop_front();
          chk("txn_addr", 64'(t.addr), 64'(e.addr));
          chk("txn_we", 64'(t.we), 64'(e.we));
          chk("txn_be", 64'(t.be), 64'(e.be));
          if (e.we) chk("txn_wdata", 64'(t.wdata), 64'(e.wdata));
        end
        d = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
        k = 0;
        stable = 1'b1;
        while ((ram_hold || k < d) && mem_req) begin
          @(negedge clk);
          k++;
          if (mem_req && ({mem_we, mem_addr, mem_be, mem_wdata} !== {t.we, t.addr, t.be, t.wdata}))
            stable = 1'b0;
        end
        if (mem_req) begin
          chk("txn_stable", 64'(stable), 64'd1);
          w = ram.exists(int'(t.addr)) ? ram[int'(t.addr)] : init_word(t.addr);
          mem_rdata = w;
          if (t.we) begin
            if (t.be[0]) w[7:0] = t.wdata[7:0];
            if (t.be[1]) w[15:8] = t.wdata[15:8];
            ram[int'(t.addr)] = w;
          end
          mem_ack = 1'b1;
          ack_cyc = cyc;
          @(negedge clk);
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [15:0] ev;
    cexp_t ec;
    int el;
    if (vid_valid) begin
      vld_cyc = cyc;
      if (exp_vid.size() == 0) fail("unexpected_vid_valid");
      else begin ev = exp_vid.pop_front(); chk("vid_data", 64'(vid_data), 64'(ev)); end
    end
    if (cpu_done) begin
      if (exp_cpu.size() == 0) fail("unexpected_cpu_done");
      else begin
        ec = exp_cpu.pop_front();
        if (ec.rd) chk("cpu_rdata", 64'(cpu_rdata), 64'(ec.data));
      end
    end
    if (ld_done) begin
      if (exp_ld.size() == 0) fail("unexpected_ld_done");
      else el = exp_ld.pop_front();
    end
  end

  function automatic logic busy();
    return (exp_txn.size() != 0) || (exp_vid.size() != 0) || (exp_cpu.size() != 0) || (exp_ld.size() != 0);
  endfunction

  task automatic wait_all(input string nm);
    int b;
    b = 0;
    while (busy() && b < 300) begin
      if (exp_cpu.size() == 0) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
      tick();
      b++;
    end
    if (b >= 300) chk(nm, 64'(exp_txn.size() + exp_vid.size() + exp_cpu.size() + exp_ld.size()), 64'd0);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_txn(input int left, input string nm);
    int b;
    b = 0;
    while (exp_txn.size() > left && b < 100) begin tick(); b++; end
    if (b >= 100) chk(nm, 64'(exp_txn.size()), 64'(left));
  endtask

  task automatic drive(input logic [2:0] m, input logic [14:0] va, input logic [22:0] ca,
                       input logic cw, input logic [7:0] cd, input logic [22:0] la, input logic [7:0] ld);
    tick();
    vid_req = m[2]; vid_addr = va;
    if (m[1]) begin cpu_rd = ~cw; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd; end
    ld_wr = m[0]; ld_addr = la; ld_wdata = ld;
    tick();
    vid_req = 1'b0; ld_wr = 1'b0;
    vid_addr = 15'($urandom); ld_addr = 23'($urandom); ld_wdata = 8'($urandom);
    cpu_addr = 23'($urandom); cpu_wdata = 8'($urandom);
  endtask

  // Expectations follow the priority order video, CPU, loader within a round.
  task automatic do_round(input logic [2:0] mask_in);
    logic [2:0] m;
    logic [14:0] va;
    logic [22:0] ca, la;
    logic cw;
    logic [7:0] cd, ld;
    logic [21:0] wa;
    logic [15:0] w;
    m = mask_in;
    if (m == 3'b000) m = 3'($urandom_range(1, 7));
    va = 15'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) va = 15'($urandom);
    ca = 23'($urandom_range(0, 127));
    if ($urandom_range(0, 3) == 0) ca[22:16] = 7'($urandom);
    la = 23'($urandom_range(0, 127));
    cw = 1'($urandom);
    cd = 8'($urandom);
    ld = 8'($urandom);
    if (m[2]) begin
      wa = 22'(VB + {7'd0, va});
      push_txn(1'b0, wa, 2'b00, 16'h0);
      exp_vid.push_back(mread(wa));
    end
    if (m[1]) begin
      wa = ca[22:1];
      if (cw) begin
        push_txn(1'b1, wa, ca[0] ? 2'b10 : 2'b01, {cd, cd});
        mwrite(wa, ca[0], cd);
        push_cpu(1'b0, 8'h00);
      end else begin
        push_txn(1'b0, wa, 2'b00, 16'h0);
        w = mread(wa);
        push_cpu(1'b1, ca[0] ? w[15:8] : w[7:0]);
      end
    end
    if (m[0]) begin
      wa = la[22:1];
      push_txn(1'b1, wa, la[0] ? 2'b10 : 2'b01, {ld, ld});
      mwrite(wa, la[0], ld);
      exp_ld.push_back(1);
    end
`ifndef LOADER_HOLD_EN
    loader_active = 1'($urandom);
`endif
    drive(m, va, ca, cw, cd, la, ld);
    wait_all("round_timeout");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int issue_cyc, drop_cyc;
    logic [15:0] w;
    reset = 1'b1;
    vid_req = 1'b0; vid_addr = 15'h0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 23'h0; cpu_wdata = 8'h0;
    ld_wr = 1'b0; ld_addr = 23'h0; ld_wdata = 8'h0;
    loader_active = 1'b0;
    repeat (3) tick();
    chk("reset_out_a", {vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_done, ld_done}, 64'd0);
    chk("reset_out_b", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Single video fetch, ack three cycles after request.
    preload(22'h001234, 16'hBEEF);
    ack_delay = 3;
    push_txn(1'b0, 22'h001234, 2'b00, 16'h0);
    exp_vid.push_back(16'hBEEF);
    tick();
    issue_cyc = cyc;
    vid_req = 1'b1; vid_addr = 15'h1234;
    tick();
    vid_req = 1'b0;
    wait_all("vid_timeout");
    chk("req_latency", 64'(req_cyc - issue_cyc), 64'd2);
    chk("valid_after_ack", 64'(vld_cyc - ack_cyc), 64'd1);
    ack_delay = -1;

    // CPU read of the odd byte, then CPU write of an even byte.
    preload(22'h006000, 16'hA55A);
    push_txn(1'b0, 22'h006000, 2'b00, 16'h0);
    push_cpu(1'b1, 8'hA5);
    drive(3'b010, 15'h0, 23'h00C001, 1'b0, 8'h00, 23'h0, 8'h0);
    wait_all("cpu_rd_timeout");
    push_txn(1'b1, 22'h000080, 2'b01, 16'h3C3C);
    push_cpu(1'b0, 8'h00);
    mwrite(22'h000080, 1'b0, 8'h3C);
    drive(3'b010, 15'h0, 23'h000100, 1'b1, 8'h3C, 23'h0, 8'h0);
    wait_all("cpu_wr_timeout");

    for (int i = 0; i < 4; i++) do_round(3'b111);
    chk("overrun_clear", 64'(vid_overrun), 64'd0);

    // Two video pulses while the port is busy merge into one fetch at the newer address.
    ack_delay = 6;
    push_txn(1'b0, 22'h000020, 2'b00, 16'h0);
    w = mread(22'h000020);
    push_cpu(1'b1, w[15:8]);
    push_txn(1'b0, 22'(VB + 22'h00077), 2'b00, 16'h0);
    exp_vid.push_back(mread(22'(VB + 22'h00077)));
    tick();
    cpu_rd = 1'b1; cpu_addr = 23'h000041;
    wait_txn(1, "ovr_cpu_timeout");
    tick();
    vid_req = 1'b1; vid_addr = 15'h0066;
    tick();
    vid_addr = 15'h0077;
    tick();
    vid_req = 1'b0;
    ack_delay = -1;
    wait_all("ovr_timeout");
    chk("overrun_set", 64'(vid_overrun), 64'd1);

    for (int i = 0; i < 50; i++) do_round(3'b000);
    chk("overrun_sticky", 64'(vid_overrun), 64'd1);

    // Reset during an in-flight video access with CPU and loader pending.
    ram_hold = 1'b1;
    push_txn(1'b0, 22'(VB + 22'h5), 2'b00, 16'h0);
    tick();
    vid_req = 1'b1; vid_addr = 15'h0005;
    tick();
    vid_req = 1'b0;
    wait_txn(0, "rst_req_timeout");
    tick();
    cpu_rd = 1'b1; cpu_addr = 23'h3; ld_wr = 1'b1; ld_addr = 23'h7; ld_wdata = 8'h11;
    tick();
    ld_wr = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mem_req_drop", 64'(mem_req), 64'd0);
    chk("rst_overrun", 64'(vid_overrun), 64'd0);
    cpu_rd = 1'b0;
    exp_txn.delete(); exp_vid.delete(); exp_cpu.delete(); exp_ld.delete();
    tick();
    ram_hold = 1'b0;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("post_rst_idle", {mem_req, vid_valid, cpu_done, ld_done}, 64'd0);

    for (int i = 0; i < 30; i++) do_round(3'b000);

`ifdef LOADER_HOLD_EN
    // Loader session: loader write served, CPU read held until session ends.
    tick();
    loader_active = 1'b1;
    push_txn(1'b1, 22'h000100, 2'b01, 16'h7777);
    mwrite(22'h000100, 1'b0, 8'h77);
    exp_ld.push_back(1);
    push_txn(1'b0, 22'h000100, 2'b00, 16'h0);
    push_cpu(1'b1, 8'h77);
    drive(3'b011, 15'h0, 23'h000200, 1'b0, 8'h0, 23'h000200, 8'h77);
    cpu_rd = 1'b1;
    begin
      int b;
      b = 0;
      while (exp_ld.size() != 0 && b < 100) begin tick(); b++; end
    end
    repeat (10) tick();
    chk("cpu_held", 64'(exp_cpu.size()), 64'd1);
    chk("hold_port_idle", 64'(mem_req), 64'd0);
    drop_cyc = cyc;
    loader_active = 1'b0;
    wait_all("hold_timeout");
    chk("cpu_after_release", 64'((req_cyc - drop_cyc) <= 3), 64'd1);
`else
    drop_cyc = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
